// File: rtl/onehot_strobe_decoder.sv
// Break-before-make strobe decoder: drives one line of a one-hot output for a
// programmable dwell time, then holds all lines low for a fixed gap.
module onehot_strobe_decoder #(
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned DWELL_W    = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  sel_valid,
    output logic                  sel_ready,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [2**SEL_W-1:0]   out,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned OUT_W = 2**SEL_W;
    localparam int unsigned GAP_W = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    // Gap counter counts down to zero, so it is loaded with one less than the gap length.
    localparam logic [GAP_W-1:0] GAP_LOAD =
        (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 32'd1);

    logic [1:0]         state_q, state_d;
    logic [DWELL_W-1:0] cnt_q,   cnt_d;
    logic [GAP_W-1:0]   gap_q,   gap_d;
    logic [OUT_W-1:0]   out_q,   out_d;
    logic               done_q,  done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                out_d = '0;
                if (sel_valid) begin
                    state_d = DRIVE;
                    out_d   = OUT_W'(1) << sel;
                    // A dwell of zero still produces a one-cycle strobe.
                    cnt_d   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
                end
            end
            DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    out_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                out_d = '0;
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = '0;
            end
        endcase
    end

    assign sel_ready = (state_q == IDLE);
    assign busy      = ~sel_ready;
    assign out       = out_q;
    assign done      = done_q;

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Directed self-checking bench for onehot_strobe_decoder (default parameters, one-cycle gap).
module tb_onehot_strobe_decoder;

    logic       clk;
    logic       rst_n;
    logic [2:0] sel;
    logic       sel_valid;
    logic       sel_ready;
    logic [7:0] dwell;
    logic [7:0] out;
    logic       busy;
    logic       done;

    int tests;
    int fails;

    onehot_strobe_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .dwell     (dwell),
        .out       (out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        sel       = 3'd3;
        dwell     = 8'd5;
        sel_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if ({out, busy, done, sel_ready} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
                fails++;
                $display("FAIL reset_hold cyc%0d out=%h busy=%b done=%b ready=%b exp out=00 busy=0 done=0 ready=1",
                         i, out, busy, done, sel_ready);
            end
        end
        sel_valid = 1'b0;
        rst_n     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if ({out, busy, done, sel_ready} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
                fails++;
                $display("FAIL reset_idle cyc%0d out=%h busy=%b done=%b ready=%b exp out=00 busy=0 done=0 ready=1",
                         i, out, busy, done, sel_ready);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_out [1:6];
        logic       exp_busy[1:6];
        logic       exp_done[1:6];
        exp_out  = '{8'h20, 8'h20, 8'h20, 8'h00, 8'h00, 8'h00};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        sel = 3'd5; dwell = 8'd3; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tests++;
            if (out !== exp_out[c] || busy !== exp_busy[c] || done !== exp_done[c] ||
                sel_ready !== !exp_busy[c]) begin
                fails++;
                $display("FAIL single cyc%0d out=%h busy=%b done=%b ready=%b exp out=%h busy=%b done=%b ready=%b",
                         c, out, busy, done, sel_ready, exp_out[c], exp_busy[c], exp_done[c], !exp_busy[c]);
            end
            step();
        end
    endtask

    task automatic test_zero_dwell();
        logic [7:0] exp_out [1:4];
        logic       exp_done[1:4];
        exp_out  = '{8'h01, 8'h00, 8'h00, 8'h00};
        exp_done = '{1'b0, 1'b0, 1'b1, 1'b0};
        sel = 3'd0; dwell = 8'd0; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tests++;
            if (out !== exp_out[c] || done !== exp_done[c]) begin
                fails++;
                $display("FAIL zero_dwell cyc%0d out=%h done=%b exp out=%h done=%b",
                         c, out, done, exp_out[c], exp_done[c]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_out [1:7];
        logic       exp_done[1:7];
        exp_out  = '{8'h80, 8'h80, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        sel = 3'd7; dwell = 8'd2; sel_valid = 1'b1;
        step();
        for (int c = 1; c <= 7; c++) begin
            tests++;
            if (out !== exp_out[c] || done !== exp_done[c] || $countones(out) > 1) begin
                fails++;
                $display("FAIL back_to_back cyc%0d out=%h done=%b exp out=%h done=%b",
                         c, out, done, exp_out[c], exp_done[c]);
            end
            if (c == 4) begin
                tests++;
                if (sel_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_ready_in_done got %b exp 1", sel_ready);
                end
                sel = 3'd2; dwell = 8'd1;
            end
            if (c == 5) sel_valid = 1'b0;
            step();
        end
    endtask

    task automatic test_ignore_busy();
        logic [7:0] exp_out [1:9];
        exp_out = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00};
        sel = 3'd3; dwell = 8'd4; sel_valid = 1'b1;
        step();
        sel = 3'd6; dwell = 8'd1;
        for (int c = 1; c <= 9; c++) begin
            tests++;
            if (out !== exp_out[c]) begin
                fails++;
                $display("FAIL ignore_busy cyc%0d out=%h exp %h", c, out, exp_out[c]);
            end
            if (c <= 5) begin
                tests++;
                if (sel_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL ignore_busy_ready cyc%0d got %b exp 0", c, sel_ready);
                end
            end
            if (c == 7) sel_valid = 1'b0;
            step();
        end
    endtask

    task automatic test_async_reset();
        sel = 3'd1; dwell = 8'd200; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        step();
        step();
        tests++;
        if (out !== 8'h02) begin
            fails++;
            $display("FAIL async_pre out=%h exp 02", out);
        end
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out !== 8'h00 || busy !== 1'b0 || sel_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_drop out=%h busy=%b ready=%b exp out=00 busy=0 ready=1", out, busy, sel_ready);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if (done !== 1'b0 || out !== 8'h00 || sel_ready !== 1'b1) begin
                fails++;
                $display("FAIL async_after cyc%0d done=%b out=%h ready=%b exp done=0 out=00 ready=1",
                         i, done, out, sel_ready);
            end
        end
        sel = 3'd4; dwell = 8'd1; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        tests++;
        if (out !== 8'h10) begin
            fails++;
            $display("FAIL async_new_c1 out=%h exp 10", out);
        end
        step();
        tests++;
        if (out !== 8'h00 || busy !== 1'b1) begin
            fails++;
            $display("FAIL async_new_c2 out=%h busy=%b exp out=00 busy=1", out, busy);
        end
        step();
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL async_new_done got %b exp 1", done);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_zero_dwell();
        test_back_to_back();
        test_ignore_busy();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
